// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - sequencer state encoding and phase constants
package seq_pkg;
    typedef enum logic [1:0] {FILL, RUN, FLUSH, HALT} seq_state_t;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;
endpackage

// File: rtl/q_phase_gen.sv
// rtl/q_phase_gen.sv - 2-bit Q-phase counter with registered strobe decode
module q_phase_gen
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       start_i,
    input  logic       park_i,
    input  logic       full_i,
    output logic [1:0] phase_o,
    output logic [4:0] stb_o
);
    logic [1:0] phase_q, phase_d;
    logic [4:0] stb_q, stb_d;

    // stb bits: 0 fetch, 1 operand read, 2 alu, 3 save, 4 pc advance
    always_comb begin
        phase_d = phase_q;
        stb_d   = '0;
        if (park_i) begin
            phase_d = Q1;
        end else if (en_i) begin
            phase_d  = start_i ? Q1 : phase_q + 2'd1;
            stb_d[0] = (phase_d == Q1);
            stb_d[1] = (phase_d == Q2) && full_i;
            stb_d[2] = (phase_d == Q3) && full_i;
            stb_d[3] = (phase_d == Q4) && full_i;
            stb_d[4] = (phase_d == Q4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= Q1;
            stb_q   <= '0;
        end else begin
            phase_q <= phase_d;
            stb_q   <= stb_d;
        end
    end

    assign phase_o = phase_q;
    assign stb_o   = stb_q;
endmodule

// File: rtl/instr_cycle_sequencer.sv
// rtl/instr_cycle_sequencer.sv - Q1..Q4 instruction-cycle FSM with flush, halt/wake
// and optional single-step (SEQ_SINGLE_STEP_EN)
module instr_cycle_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RESET_NOPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             branch_taken,
    input  logic             skip_req,
    input  logic             halt_req,
    input  logic             wake_req,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step_mode,
    input  logic             step_req,
`endif
    output logic [1:0]       q_phase,
    output logic             inst_fetch,
    output logic             data_fetch,
    output logic             alu_results,
    output logic             save_files,
    output logic             pc_en,
    output logic             flush_cycle,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);
    localparam logic [1:0] FILL_INIT = 2'(RESET_NOPS);

    seq_state_t       state_q, state_d;
    logic             pend_q, pend_d;
    logic             idle_q, idle_d;
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ph_en, ph_start, ph_park;
    logic             step_ok, step_park;
    logic [1:0]       phase_w;
    logic [4:0]       stb_w;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) step_q <= 1'b0;
        else        step_q <= step_req;
    end

    assign step_ok   = !step_mode || (step_req && !step_q);
    assign step_park = step_mode;
`else
    assign step_ok   = 1'b1;
    assign step_park = 1'b0;
`endif

    // idle_q: sitting at Q1 with that phase not yet executed (after reset, halt, step park)
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        idle_d   = idle_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        ph_en    = 1'b0;
        ph_start = 1'b0;
        ph_park  = 1'b0;
        if (run_en) begin
            if (state_q == HALT) begin
                if (wake_req) begin
                    state_d  = pend_q ? FLUSH : RUN;
                    pend_d   = 1'b0;
                    idle_d   = 1'b0;
                    ph_en    = 1'b1;
                    ph_start = 1'b1;
                end
            end else if (idle_q) begin
                if (step_ok) begin
                    idle_d   = 1'b0;
                    ph_en    = 1'b1;
                    ph_start = 1'b1;
                end
            end else begin
                ph_en = 1'b1;
                if (phase_w == Q3 && state_q == RUN && (branch_taken || skip_req))
                    pend_d = 1'b1;
                if (phase_w == Q4) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (state_q)
                        FILL: begin
                            fill_d = fill_q - 2'd1;
                            if (fill_q == 2'd1) state_d = halt_req ? HALT : RUN;
                        end
                        RUN: begin
                            if (halt_req) begin
                                state_d = HALT;
                            end else if (pend_q) begin
                                state_d = FLUSH;
                                pend_d  = 1'b0;
                            end
                        end
                        default: state_d = halt_req ? HALT : RUN;
                    endcase
                    if (state_d == HALT || step_park) begin
                        ph_park = 1'b1;
                        idle_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            pend_q  <= 1'b0;
            idle_q  <= 1'b1;
            fill_q  <= FILL_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idle_q  <= idle_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    q_phase_gen u_phase (
        .clk     (clk),
        .reset   (reset),
        .en_i    (ph_en),
        .start_i (ph_start),
        .park_i  (ph_park),
        .full_i  (state_d == RUN),
        .phase_o (phase_w),
        .stb_o   (stb_w)
    );

    assign q_phase     = phase_w;
    assign inst_fetch  = stb_w[0];
    assign data_fetch  = stb_w[1];
    assign alu_results = stb_w[2];
    assign save_files  = stb_w[3];
    assign pc_en       = stb_w[4];
    assign flush_cycle = (state_q == FILL) || (state_q == FLUSH);
    assign halted      = (state_q == HALT);
    assign cycle_count = cnt_q;
endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// tb/tb_instr_cycle_sequencer.sv - vector table, corner sequences and random run vs reference model
module tb_instr_cycle_sequencer;
    localparam int CNT_W = 4;
    localparam int K_FILL = 0, K_RUN = 1, K_FLUSH = 2, K_HALT = 3;

    logic clk = 1'b0;
    logic reset, run_en, branch_taken, skip_req, halt_req, wake_req;
    logic [1:0] q_phase;
    logic inst_fetch, data_fetch, alu_results, save_files, pc_en, flush_cycle, halted;
    logic [CNT_W-1:0] cycle_count;
`ifdef SEQ_SINGLE_STEP_EN
    logic step_mode, step_req;
`endif

    always #5 clk = ~clk;

    instr_cycle_sequencer #(.CNT_W(CNT_W), .RESET_NOPS(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .run_en       (run_en),
        .branch_taken (branch_taken),
        .skip_req     (skip_req),
        .halt_req     (halt_req),
        .wake_req     (wake_req),
`ifdef SEQ_SINGLE_STEP_EN
        .step_mode    (step_mode),
        .step_req     (step_req),
`endif
        .q_phase      (q_phase),
        .inst_fetch   (inst_fetch),
        .data_fetch   (data_fetch),
        .alu_results  (alu_results),
        .save_files   (save_files),
        .pc_en        (pc_en),
        .flush_cycle  (flush_cycle),
        .halted       (halted),
        .cycle_count  (cycle_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: m_pos is the last executed phase (-1 = waiting at Q1)
    int m_kind, m_pos, m_fills, m_count;
    bit m_strobed, m_owed, m_step_prev;

    typedef struct {
        bit          run_en;
        bit          br;
        bit          sk;
        bit          hl;
        bit          wk;
        logic [12:0] exp;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [12:0] dut_out();
        return {q_phase, inst_fetch, data_fetch, alu_results, save_files, pc_en,
                flush_cycle, halted, cycle_count};
    endfunction

    function automatic logic [12:0] model_out();
        logic [1:0] ph;
        bit full;
        ph   = (m_pos < 0) ? 2'd0 : 2'(m_pos);
        full = (m_kind == K_RUN);
        return {ph, m_strobed && m_pos == 0, m_strobed && m_pos == 1 && full,
                m_strobed && m_pos == 2 && full, m_strobed && m_pos == 3 && full,
                m_strobed && m_pos == 3, m_kind == K_FILL || m_kind == K_FLUSH,
                m_kind == K_HALT, 4'(m_count)};
    endfunction

    task automatic model_reset();
        m_kind = K_FILL; m_pos = -1; m_fills = 1; m_count = 0;
        m_strobed = 0; m_owed = 0; m_step_prev = 0;
    endtask

    task automatic model_edge();
        bit smode, sedge;
`ifdef SEQ_SINGLE_STEP_EN
        smode = step_mode;
        sedge = step_req && !m_step_prev;
        m_step_prev = step_req;
`else
        smode = 0;
        sedge = 0;
`endif
        m_strobed = 0;
        if (run_en) begin
            if (m_kind == K_HALT) begin
                if (wake_req) begin
                    m_kind = m_owed ? K_FLUSH : K_RUN;
                    m_owed = 0; m_pos = 0; m_strobed = 1;
                end
            end else if (m_pos < 0) begin
                if (!smode || sedge) begin m_pos = 0; m_strobed = 1; end
            end else if (m_pos < 3) begin
                if (m_pos == 2 && m_kind == K_RUN && (branch_taken || skip_req)) m_owed = 1;
                m_pos++; m_strobed = 1;
            end else begin
                m_count = (m_count + 1) % 16;
                if (m_kind == K_FILL) begin
                    m_fills--;
                    if (m_fills == 0) m_kind = halt_req ? K_HALT : K_RUN;
                end else if (m_kind == K_RUN) begin
                    if (halt_req) m_kind = K_HALT;
                    else if (m_owed) begin m_kind = K_FLUSH; m_owed = 0; end
                end else begin
                    m_kind = halt_req ? K_HALT : K_RUN;
                end
                if (m_kind == K_HALT || smode) m_pos = -1;
                else begin m_pos = 0; m_strobed = 1; end
            end
        end
    endtask

    task automatic check_vec(input string tag, input logic [12:0] got, input logic [12:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_vec(tag, dut_out(), model_out());
    endtask

    task automatic do_reset();
        reset = 0; run_en = 1; branch_taken = 0; skip_req = 0; halt_req = 0; wake_req = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_vec("reset_state", dut_out(), 13'b00_00000_1_0_0000);
        reset = 1;
    endtask

    task automatic wait_run_phase(input logic [1:0] p, input string tag);
        int n = 0;
        while (!(q_phase == p && !flush_cycle && !halted &&
                 (inst_fetch | data_fetch | alu_results | save_files | pc_en)) && n < 40) begin
            tick(tag);
            n++;
        end
        if (n >= 40) begin
            vectors++; miscompares++;
            $display("FAIL %s: run phase %0d not reached in 40 clks", tag, p);
        end
    endtask

    initial begin
        int fl, sv, bad, cexp;
`ifdef SEQ_SINGLE_STEP_EN
        step_mode = 0; step_req = 0;
`endif
        tbl[0] = '{1, 0, 0, 0, 0, {2'd0, 5'b10000, 1'b1, 1'b0, 4'd0}};
        tbl[1] = '{1, 0, 0, 0, 0, {2'd1, 5'b00000, 1'b1, 1'b0, 4'd0}};
        tbl[2] = '{1, 0, 0, 0, 0, {2'd2, 5'b00000, 1'b1, 1'b0, 4'd0}};
        tbl[3] = '{1, 0, 0, 0, 0, {2'd3, 5'b00001, 1'b1, 1'b0, 4'd0}};
        tbl[4] = '{1, 0, 0, 0, 0, {2'd0, 5'b10000, 1'b0, 1'b0, 4'd1}};
        tbl[5] = '{1, 0, 0, 0, 0, {2'd1, 5'b01000, 1'b0, 1'b0, 4'd1}};
        tbl[6] = '{1, 0, 0, 0, 0, {2'd2, 5'b00100, 1'b0, 1'b0, 4'd1}};
        tbl[7] = '{1, 0, 0, 0, 0, {2'd3, 5'b00011, 1'b0, 1'b0, 4'd1}};
        tbl[8] = '{1, 0, 0, 0, 0, {2'd0, 5'b10000, 1'b0, 1'b0, 4'd2}};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_en = tbl[i].run_en; branch_taken = tbl[i].br; skip_req = tbl[i].sk;
            halt_req = tbl[i].hl; wake_req = tbl[i].wk;
            tick($sformatf("model_tbl%0d", i));
            check_vec($sformatf("tbl%0d", i), dut_out(), tbl[i].exp);
        end
        run_en = 1; branch_taken = 0; skip_req = 0; halt_req = 0; wake_req = 0;

        // branch+skip together -> one flush; branch inside the flush is ignored
        wait_run_phase(2'd2, "br_wait");
        branch_taken = 1; skip_req = 1;
        tick("br_q3");
        branch_taken = 0; skip_req = 0;
        fl = 0; sv = 0;
        for (int k = 0; k < 4; k++) begin
            tick("flush");
            fl += int'(flush_cycle); sv += int'(save_files);
            branch_taken = (k == 2);
        end
        check1("flush_len", fl, 4);
        check1("flush_no_save", sv, 0);
        fl = 0;
        for (int k = 0; k < 4; k++) begin
            tick("post_flush");
            fl += int'(flush_cycle);
        end
        check1("post_flush_run", fl, 0);

        // halt, hold 20 clks, wake
        wait_run_phase(2'd3, "halt_wait");
        halt_req = 1;
        tick("halt_q4");
        halt_req = 0;
        check1("halt_enter", int'(halted), 1);
        cexp = m_count;
        bad = 0;
        repeat (20) begin
            tick("halt_hold");
            if (q_phase != 2'd0 || !halted || inst_fetch || pc_en) bad++;
        end
        check1("halt_held", bad, 0);
        check1("halt_cnt_frozen", int'(cycle_count), cexp);
        wake_req = 1;
        tick("wake");
        wake_req = 0;
        check1("wake_fetch", int'(inst_fetch), 1);
        check1("wake_unhalted", int'(halted), 0);

        // wake already high on entry: exactly one halted clk
        wait_run_phase(2'd3, "halt2_wait");
        halt_req = 1; wake_req = 1;
        tick("halt2_q4");
        halt_req = 0;
        check1("halt2_enter", int'(halted), 1);
        tick("halt2_wake");
        wake_req = 0;
        check1("halt2_fetch", int'(inst_fetch && !halted), 1);

        // freeze at Q2, resume with Q3
        wait_run_phase(2'd1, "freeze_wait");
        check1("pre_freeze_data", int'(data_fetch), 1);
        run_en = 0;
        fl = 0; bad = 0;
        repeat (5) begin
            tick("frozen");
            fl += int'(data_fetch);
            if (q_phase != 2'd1 || alu_results) bad++;
        end
        check1("frozen_no_data", fl, 0);
        check1("frozen_hold", bad, 0);
        run_en = 1;
        tick("resume");
        check1("resume_alu", int'(alu_results), 1);

        // reset asserted during Q3 clears strobes immediately
        reset = 0;
        #1;
        check_vec("reset_mid", dut_out(), 13'b00_00000_1_0_0000);
        model_reset();
        @(negedge clk);
        reset = 1;

        // counter wrap with CNT_W=4
        bad = 0;
        while (cycle_count != 4'd15 && bad < 100) begin tick("wrap_run"); bad++; end
        check1("wrap_reach15", int'(cycle_count), 15);
        bad = 0;
        while (cycle_count == 4'd15 && bad < 8) begin tick("wrap_edge"); bad++; end
        check1("wrap_to0", int'(cycle_count), 0);

`ifdef SEQ_SINGLE_STEP_EN
        step_mode = 1;
        bad = 0;
        while (!(q_phase == 2'd0 && !inst_fetch && !halted) && bad < 10) begin tick("park"); bad++; end
        cexp = (m_count + 3) % 16;
        for (int p = 0; p < 3; p++) begin
            step_req = 1;
            tick("step_pulse");
            step_req = 0;
            repeat (6) tick("step_run");
        end
        repeat (8) tick("step_idle");
        check1("step_count", int'(cycle_count), cexp);
        step_mode = 0;
`endif

        // randomized run against the model
        for (int i = 0; i < 400; i++) begin
            run_en       = ($urandom_range(0, 7) != 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            skip_req     = ($urandom_range(0, 4) == 0);
            halt_req     = ($urandom_range(0, 11) == 0);
            wake_req     = ($urandom_range(0, 2) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
